// File: rtl/iso15_pkg.sv
// Shared types and constants for the ISO15693 tag-side response encoder.
// The optional CRC stage in iso15_tag_tx is enabled by defining ISO15_TX_CRC_EN.
package iso15_pkg;

  typedef enum logic {CHIP_U = 1'b0, CHIP_M = 1'b1} chip_t;

  typedef enum logic [2:0] {StIdle, StSof, StData, StCrc, StEof, StDone} state_t;

  // Bit i set means chip i of the pattern is a modulated (M) chip.
  localparam logic [7:0]  SOF_PAT  = 8'hB8;  // U U U M M M U M
  localparam logic [7:0]  EOF_PAT  = 8'h1D;  // M U M M M U U U

  localparam logic [15:0] CRC_POLY = 16'h8408;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Chip type for a position in the frame; data/CRC bits are M U for 0 and U M for 1.
  function automatic chip_t chip_sel(state_t st, logic [3:0] idx, logic half, logic bitv);
    chip_t c;
    c = CHIP_U;
    case (st)
      StSof:          c = chip_t'(SOF_PAT[idx[2:0]]);
      StEof:          c = chip_t'(EOF_PAT[idx[2:0]]);
      StData, StCrc:  c = (half == bitv) ? CHIP_M : CHIP_U;
      default:        c = CHIP_U;
    endcase
    return c;
  endfunction

  // One reflected CRC-16 step for a single payload bit.
  function automatic logic [15:0] crc_step(logic [15:0] crc, logic b);
    logic fb;
    logic [15:0] nx;
    fb = crc[0] ^ b;
    nx = {1'b0, crc[15:1]};
    if (fb) nx = nx ^ CRC_POLY;
    return nx;
  endfunction

endpackage

// File: rtl/iso15_subcarrier_gen.sv
// Chip waveform generator: produces the registered load-modulation level and a
// strobe marking the last clock of the chip currently on air.
module iso15_subcarrier_gen #(
  parameter int unsigned SC1_DIV    = 32,
  parameter int unsigned SC2_DIV    = 28,
  parameter int unsigned SC1_PULSES = 8,
  parameter int unsigned SC2_PULSES = 9
) (
  input  logic ck_1356meg,
  input  logic rst,
  input  logic start,       // frame starts at this edge; take mode inputs directly
  input  logic run,         // next cycle belongs to a chip
  input  logic chip_m_nxt,  // type of the chip on air next cycle
  input  logic two_sc,
  input  logic low_rate,
  output logic mod,
  output logic chip_end
);

  localparam logic [5:0] Div1  = 6'(SC1_DIV);
  localparam logic [5:0] Div2  = 6'(SC2_DIV);
  localparam logic [5:0] Half1 = 6'(SC1_DIV / 2);
  localparam logic [5:0] Half2 = 6'(SC2_DIV / 2);
  localparam logic [5:0] Pul1  = 6'(SC1_PULSES);
  localparam logic [5:0] Pul2  = 6'(SC2_PULSES);
  localparam logic [5:0] Pul1L = 6'(SC1_PULSES * 4);
  localparam logic [5:0] Pul2L = 6'(SC2_PULSES * 4);

  logic       active_q, chip_m_q, two_q, low_q, mod_q;
  logic [5:0] ph_q, ph_d, per_q, per_d;
  logic [5:0] div_cur, npul_cur;
  logic       two_n, low_n, restart, mod_d, use_sc2;

  // Length of the chip currently on air and its end strobe.
  always_comb begin
    use_sc2  = !chip_m_q && two_q;
    div_cur  = use_sc2 ? Div2 : Div1;
    npul_cur = use_sc2 ? (low_q ? Pul2L : Pul2) : (low_q ? Pul1L : Pul1);
    chip_end = active_q && (ph_q == div_cur - 6'd1) && (per_q == npul_cur - 6'd1);
  end

  // Phase/period counters and modulation level for the next cycle.
  always_comb begin
    two_n   = start ? two_sc : two_q;
    low_n   = start ? low_rate : low_q;
    restart = start || chip_end;
    ph_d    = '0;
    per_d   = '0;
    if (run && !restart) begin
      if (ph_q == div_cur - 6'd1) begin
        per_d = per_q + 6'd1;
      end else begin
        ph_d  = ph_q + 6'd1;
        per_d = per_q;
      end
    end
    if (chip_m_nxt) mod_d = run && (ph_d < Half1);
    else            mod_d = run && two_n && (ph_d < Half2);
  end

  // State registers.
  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      active_q <= 1'b0;
      chip_m_q <= 1'b0;
      two_q    <= 1'b0;
      low_q    <= 1'b0;
      ph_q     <= '0;
      per_q    <= '0;
      mod_q    <= 1'b0;
    end else begin
      active_q <= run;
      chip_m_q <= chip_m_nxt;
      two_q    <= two_n;
      low_q    <= low_n;
      ph_q     <= ph_d;
      per_q    <= per_d;
      mod_q    <= mod_d;
    end
  end

  assign mod = mod_q;

endmodule

// File: rtl/iso15_tag_tx.sv
// ISO15693 tag response encoder: SOF, Manchester data, optional CRC, EOF.
// Define ISO15_TX_CRC_EN to append the complemented CRC-16 after the payload.
module iso15_tag_tx #(
  parameter int unsigned SC1_DIV    = 32,
  parameter int unsigned SC2_DIV    = 28,
  parameter int unsigned SC1_PULSES = 8,
  parameter int unsigned SC2_PULSES = 9
) (
  input  logic       ck_1356meg,
  input  logic       rst,
  input  logic       two_sc,
  input  logic       low_rate,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       mod,
  output logic       busy,
  output logic       done,
  output logic       underrun
);
  import iso15_pkg::*;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       half_q, half_d;
  logic [7:0] sh_q, sh_d, nxt_q, nxt_d;
  logic       nxt_vld_q, nxt_vld_d, nxt_last_q, nxt_last_d;
  logic       last_q, last_d, under_q, under_d;
  logic       armed_q;
  logic       start, run, chip_end, chip_m_nxt, hs, have_nxt, nxt_is_last, bit_d;
  logic [7:0] nxt_byte;
`ifdef ISO15_TX_CRC_EN
  logic [15:0] crc_q, crc_d, crcsh_q, crcsh_d, crc_nx;
`endif

  // Ready in IDLE (held off for the first cycle after reset) or during bit 7 of a non-last byte.
  always_comb begin
    tx_ready = 1'b0;
    if (state_q == StIdle) tx_ready = armed_q;
    else if (state_q == StData && idx_q == 4'd7 && !last_q && !nxt_vld_q) tx_ready = 1'b1;
  end

  // Frame sequencing; advances on the generator's chip-end strobe.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    half_d     = half_q;
    sh_d       = sh_q;
    nxt_d      = nxt_q;
    nxt_vld_d  = nxt_vld_q;
    nxt_last_d = nxt_last_q;
    last_d     = last_q;
    under_d    = under_q;
    start      = 1'b0;
`ifdef ISO15_TX_CRC_EN
    crc_d      = crc_q;
    crcsh_d    = crcsh_q;
    crc_nx     = crc_step(crc_q, sh_q[0]);
`endif
    hs          = tx_valid && tx_ready;
    // A byte handed over on the very edge that ends bit 7 still counts as prefetched.
    have_nxt    = nxt_vld_q || hs;
    nxt_byte    = nxt_vld_q ? nxt_q : tx_data;
    nxt_is_last = nxt_vld_q ? nxt_last_q : tx_last;
    case (state_q)
      StIdle: begin
        if (hs) begin
          start     = 1'b1;
          state_d   = StSof;
          idx_d     = '0;
          half_d    = 1'b0;
          sh_d      = tx_data;
          last_d    = tx_last;
          nxt_vld_d = 1'b0;
          under_d   = 1'b0;
`ifdef ISO15_TX_CRC_EN
          crc_d     = CRC_INIT;
`endif
        end
      end
      StSof: begin
        if (chip_end) begin
          if (idx_q == 4'd7) begin
            state_d = StData;
            idx_d   = '0;
            half_d  = 1'b0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StData: begin
        if (hs) begin
          nxt_d      = tx_data;
          nxt_last_d = tx_last;
          nxt_vld_d  = 1'b1;
        end
        if (chip_end) begin
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            sh_d   = {1'b0, sh_q[7:1]};
`ifdef ISO15_TX_CRC_EN
            crc_d  = crc_nx;
`endif
            if (idx_q != 4'd7) begin
              idx_d = idx_q + 4'd1;
            end else begin
              idx_d = '0;
              if (have_nxt && !last_q) begin
                sh_d      = nxt_byte;
                last_d    = nxt_is_last;
                nxt_vld_d = 1'b0;
              end else begin
                if (!last_q) under_d = 1'b1;
`ifdef ISO15_TX_CRC_EN
                state_d = StCrc;
                crcsh_d = ~crc_nx;
`else
                state_d = StEof;
`endif
              end
            end
          end
        end
      end
`ifdef ISO15_TX_CRC_EN
      StCrc: begin
        if (chip_end) begin
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d  = 1'b0;
            crcsh_d = {1'b0, crcsh_q[15:1]};
            if (idx_q == 4'd15) begin
              state_d = StEof;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
      end
`endif
      StEof: begin
        if (chip_end) begin
          if (idx_q == 4'd7) state_d = StDone;
          else               idx_d   = idx_q + 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    run   = (state_d == StSof) || (state_d == StData) || (state_d == StCrc) ||
            (state_d == StEof);
    bit_d = sh_d[0];
`ifdef ISO15_TX_CRC_EN
    if (state_d == StCrc) bit_d = crcsh_d[0];
`endif
    chip_m_nxt = (chip_sel(state_d, idx_d, half_d, bit_d) == CHIP_M);
  end

  // State registers.
  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      half_q     <= 1'b0;
      sh_q       <= '0;
      nxt_q      <= '0;
      nxt_vld_q  <= 1'b0;
      nxt_last_q <= 1'b0;
      last_q     <= 1'b0;
      under_q    <= 1'b0;
      armed_q    <= 1'b0;
`ifdef ISO15_TX_CRC_EN
      crc_q      <= '0;
      crcsh_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      half_q     <= half_d;
      sh_q       <= sh_d;
      nxt_q      <= nxt_d;
      nxt_vld_q  <= nxt_vld_d;
      nxt_last_q <= nxt_last_d;
      last_q     <= last_d;
      under_q    <= under_d;
      armed_q    <= 1'b1;
`ifdef ISO15_TX_CRC_EN
      crc_q      <= crc_d;
      crcsh_q    <= crcsh_d;
`endif
    end
  end

  iso15_subcarrier_gen #(
    .SC1_DIV    (SC1_DIV),
    .SC2_DIV    (SC2_DIV),
    .SC1_PULSES (SC1_PULSES),
    .SC2_PULSES (SC2_PULSES)
  ) u_sc_gen (
    .ck_1356meg (ck_1356meg),
    .rst        (rst),
    .start      (start),
    .run        (run),
    .chip_m_nxt (chip_m_nxt),
    .two_sc     (two_sc),
    .low_rate   (low_rate),
    .mod        (mod),
    .chip_end   (chip_end)
  );

  assign busy     = (state_q != StIdle) && (state_q != StDone);
  assign done     = (state_q == StDone);
  assign underrun = under_q;

endmodule

// File: tb/tb_iso15_tag_tx.sv
// Self-checking bench for iso15_tag_tx: expected chips are queued when a frame
// is launched and popped as the DUT puts each chip on air.
`timescale 1ns/1ps
module tb_iso15_tag_tx;

  logic       clk = 1'b0;
  logic       rst, two_sc, low_rate, tx_valid, tx_last;
  logic [7:0] tx_data;
  logic       tx_ready, mod, busy, done, underrun;

  always #5 clk = ~clk;

  iso15_tag_tx dut (
    .ck_1356meg (clk),
    .rst        (rst),
    .two_sc     (two_sc),
    .low_rate   (low_rate),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .mod        (mod),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  typedef struct {
    bit m;
    bit win;
    bit win_start;
  } chip_s;

  int         vectors = 0;
  int         miscompares = 0;
  chip_s      exp_q[$];
  logic [7:0] pay[$];
  bit         plast[$];
  bit         sof_seq[8] = '{0, 0, 0, 1, 1, 1, 0, 1};
  bit         eof_seq[8] = '{1, 0, 1, 1, 1, 0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] crc_model();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (pay[i]) begin
      for (int b = 0; b < 8; b++) begin
        logic fb;
        fb = c[0] ^ pay[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return ~c;
  endfunction

  task automatic push_chip(input bit m, input bit win, input bit ws);
    chip_s e;
    e.m = m;
    e.win = win;
    e.win_start = ws;
    exp_q.push_back(e);
  endtask

  task automatic push_bit(input bit v, input bit win);
    push_chip(!v, win, win);
    push_chip(v, win, 1'b0);
  endtask

  // Launch a frame from pay/plast and check every chip, tx_ready and the end of frame.
  task automatic run_frame(input bit two, input bit low, input int delay, input bit exp_under,
                           input bit flip, input string name);
    int         k, len, feed_idx, wcnt, nchip, cyc, emod, erdy, ectl, run_len, max_run;
    bit         hs, exp_mod, exp_rdy, last_mod;
    chip_s      e;
    logic [15:0] crc;
    k = low ? 4 : 1;
    for (int i = 0; i < 8; i++) push_chip(sof_seq[i], 1'b0, 1'b0);
    foreach (pay[j]) for (int b = 0; b < 8; b++) push_bit(pay[j][b], (b == 7) && !plast[j]);
`ifdef ISO15_TX_CRC_EN
    crc = crc_model();
    for (int b = 0; b < 16; b++) push_bit(crc[b], 1'b0);
`else
    crc = 16'h0;
`endif
    for (int i = 0; i < 8; i++) push_chip(eof_seq[i], 1'b0, 1'b0);
    nchip = exp_q.size();

    tx_data  = pay[0];
    tx_last  = plast[0];
    two_sc   = two;
    low_rate = low;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    if (flip) begin
      two_sc   = !two;
      low_rate = !low;
    end
    chk({name, "_underrun_clr"}, underrun, 0);

    feed_idx = 1; wcnt = 0; hs = 0; cyc = 0; ectl = 0; run_len = 0; max_run = 0;
    last_mod = 1'b0;
    for (int n = 0; n < nchip; n++) begin
      e = exp_q.pop_front();
      len = e.m ? 256 * k : (two ? 252 * k : 256 * k);
      if (e.win_start) begin
        wcnt = 0;
        hs   = 0;
      end
      emod = 0;
      erdy = 0;
      for (int c = 0; c < len; c++) begin
        exp_mod = e.m ? ((c % 32) < 16) : (two && ((c % 28) < 14));
        if (mod !== exp_mod) emod++;
        exp_rdy = e.win && !hs;
        if (tx_ready !== exp_rdy) erdy++;
        if (busy !== 1'b1 || done !== 1'b0) ectl++;
        if (cyc > 0 && mod === last_mod) run_len++;
        else run_len = 1;
        if (run_len > max_run) max_run = run_len;
        last_mod = mod;
        tx_valid = 1'b0;
        if (e.win && !hs && wcnt == delay && feed_idx < pay.size()) begin
          tx_valid = 1'b1;
          tx_data  = pay[feed_idx];
          tx_last  = plast[feed_idx];
          feed_idx++;
          hs = 1;
        end
        if (e.win) wcnt++;
        cyc++;
        step();
      end
      tx_valid = 1'b0;
      chk($sformatf("%s_chip%0d_mod", name, n), emod, 0);
      chk($sformatf("%s_chip%0d_ready", name, n), erdy, 0);
    end
    chk({name, "_busy_during_frame"}, ectl, 0);
    if (!two) chk({name, "_frame_len"}, cyc, nchip * 256 * k);
    else chk({name, "_max_run_le16"}, (max_run <= 16) ? 1 : 0, 1);
    chk({name, "_done"}, done, 1);
    chk({name, "_busy_end"}, busy, 0);
    chk({name, "_mod_end"}, mod, 0);
    chk({name, "_ready_done"}, tx_ready, 0);
    chk({name, "_underrun"}, underrun, exp_under);
    step();
    chk({name, "_done_pulse"}, done, 0);
    chk({name, "_ready_idle"}, tx_ready, 1);
    two_sc   = 1'b0;
    low_rate = 1'b0;
    pay.delete();
    plast.delete();
  endtask

  initial begin
    rst = 1'b1; two_sc = 1'b0; low_rate = 1'b0; tx_valid = 1'b0; tx_last = 1'b0;
    tx_data = 8'h00;
    step();
    step();
    chk("rst_mod", mod, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready", tx_ready, 0);
    rst = 1'b0;
    step();
    chk("idle_ready", tx_ready, 1);

    // One byte, single subcarrier; mode inputs flipped mid-frame must be ignored.
    pay = '{8'h00}; plast = '{1'b1};
    run_frame(1'b0, 1'b0, 0, 1'b0, 1'b1, "b00");

    // Two bytes at low rate with a delayed prefetch during bit 7.
    pay = '{8'h01, 8'h80}; plast = '{1'b0, 1'b1};
    run_frame(1'b0, 1'b1, 300, 1'b0, 1'b0, "lowrate");

    // Reset in the middle of the data phase.
    tx_data = 8'h55; tx_last = 1'b1; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (3000) step();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_mod", mod, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", tx_ready, 0);
    step();
    chk("abort_ready_rearm", tx_ready, 1);

    // Missing second byte.
    pay = '{8'h55}; plast = '{1'b0};
    run_frame(1'b0, 1'b0, 0, 1'b1, 1'b0, "underrun");

    // Two-subcarrier frame; also confirms the underrun flag clears at frame start.
    pay = '{8'hFF}; plast = '{1'b1};
    run_frame(1'b1, 1'b0, 0, 1'b0, 1'b0, "twosc");

`ifdef ISO15_TX_CRC_EN
    pay = '{8'h26, 8'h01, 8'h00}; plast = '{1'b0, 1'b0, 1'b1};
    chk("crc_model", crc_model(), 16'h0AF6);
    run_frame(1'b0, 1'b0, 10, 1'b0, 1'b0, "crc");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iso15_tag_tx.md
Name: iso15_tag_tx

Overview:
- ISO15693 tag-side response encoder: the transmit counterpart of the HF reader demodulator; used by the tag simulation mode.
- Takes bytes from the ARM-side byte loader and emits a Manchester-coded frame (SOF, data, optional CRC, EOF) as a load-modulation signal.
- Supports single-subcarrier (fc/32, 423.75 kHz) and two-subcarrier FSK (fc/32 and fc/28, 484.28 kHz), at high or low data rate.
- Sits between the SSP byte deserializer and the antenna load-modulation driver.

Parameters:
- SC1_DIV, 32: clocks per period of subcarrier 1 (fc/32).
- SC2_DIV, 28: clocks per period of subcarrier 2 (fc/28), used in two-subcarrier mode only.
- SC1_PULSES, 8: subcarrier-1 pulses per high-rate modulated chip.
- SC2_PULSES, 9: subcarrier-2 pulses per high-rate unmodulated chip in two-subcarrier mode.

Ports:
- ck_1356meg  in  1  13.56 MHz clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- two_sc  in  1  1 = two-subcarrier FSK, 0 = single subcarrier; sampled at frame start.
- low_rate  in  1  1 = low data rate (all chips x4); sampled at frame start.
- tx_data  in  8  byte to send, LSB first.
- tx_valid  in  1  tx_data valid.
- tx_last  in  1  qualifies tx_data as the final payload byte.
- tx_ready  out  1  byte accepted when tx_valid && tx_ready.
- mod  out  1  load-modulation output, registered.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last EOF chip.
- underrun  out  1  sticky; set if the next byte was missing mid-frame; cleared at next frame start.

Behaviour:
- Reset values: mod=0, busy=0, done=0, underrun=0, tx_ready=0; state=IDLE; all counters 0.
- Chip unit: a frame is a sequence of M/U chips.
  - M chip: SC1_PULSES x K periods of fc/32; mod high for the first SC1_DIV/2 clocks of each period, low for the rest. Length 256 x K clocks.
  - U chip, single subcarrier: mod=0 for 256 x K clocks.
  - U chip, two_sc: SC2_PULSES x K periods of fc/28, high 14 clocks then low 14. Length 252 x K clocks.
  - K = 4 if low_rate, else 1.
- Chip sequences:
  - SOF = U U U M M M U M.
  - Bit 0 = M U; bit 1 = U M.
  - EOF = M U M M M U U U.
- FSM states and transitions:
  - IDLE: tx_ready=1. On tx_valid, latch the byte, tx_last, two_sc and low_rate; clear underrun; busy=1; go to SOF. The first mod edge follows in the next cycle.
  - SOF: emit the 8 SOF chips, then go to DATA.
  - DATA: shift out 8 bits LSB first.
    - tx_ready=1 during bit 7 of a byte only if that byte was not last.
    - A handshake during bit 7 prefetches the next byte, which starts seamlessly with no gap chip.
    - If bit 7 ends with no prefetched byte and the byte was not last: set underrun and go to EOF (or to CRC when the feature is enabled).
    - Last byte done: go to CRC when the feature is enabled, else EOF.
  - EOF: emit the EOF chips, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, mod=0, return to IDLE.
- tx_ready=0 in all other states; handshakes there are ignored.
- Mode inputs changing mid-frame have no effect.
- Subcarrier phase restarts at the start of every chip.
- mod is 0 whenever busy=0.
- rst mid-frame: abort immediately to reset values on the next edge; no EOF is sent.
- Latency: tx_valid in IDLE at cycle n gives mod=0 (U chip) from n+1; in two_sc mode mod=1 at n+1.
- Single-subcarrier frame length: (8 + 16N + 8) x 256 x K clocks, with N = number of payload bytes.

Optional Feature:
- Macro ISO15_TX_CRC_EN.
- Defined:
  - Adds state CRC between DATA and EOF.
  - CRC-16/ISO15693 (reflected poly 0x8408, init 0xFFFF, final complement) computed over the sent payload bytes, updated per bit as shifted.
  - The complemented CRC is sent low byte first, 16 bits, LSB first.
  - On underrun, the CRC covers only the bytes actually sent.
- Undefined: no CRC logic; DATA goes straight to EOF.

Decomposition:
- Shared package iso15_pkg:
  - chip-type enum (CHIP_M, CHIP_U);
  - state enum;
  - SOF/EOF chip patterns as 8-bit constants;
  - CRC polynomial and init constants.
- One sub-module, iso15_subcarrier_gen: given chip type, two_sc and K, produces mod and a chip_end strobe.

Test Plan:
- Single subcarrier, high rate, one byte 0x00 with tx_last: frame is 32 chips = 8192 clocks. Sequence: U,U,U,M,M,M,U,M, then (M,U) x8, then the EOF chips. Each M chip has 8 pulses of 16 high/16 low. done pulses at cycle 8193.
- Byte 0x01 then 0x80, low_rate=1: bit0 of byte 0 and bit7 of byte 1 are U,M; every chip is 1024 clocks. tx_ready is high only during bit 7 of byte 0. underrun=0.
- two_sc=1, byte 0xFF: every U chip carries 9 periods of 14/14; M chips carry 8 periods of 16/16. mod is never constant for more than 16 clocks while busy.
- Underrun: byte 0x55 without tx_last and tx_valid held low: after 8 bits, underrun=1 and EOF follows directly. The next frame start clears underrun.
- rst asserted mid-DATA: next cycle mod=0, busy=0, tx_ready=0. A fresh frame then starts normally.
- ISO15_TX_CRC_EN, payload 0x26 0x01 0x00: CRC bytes on air are 0xF6 then 0x0A (LSB first); total chips 8 + 80 + 8.
